// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register responder: two RW control registers and two RO
// status words. AW and W are held independently and commit together.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] reg0_out,
  output logic [DATA_WIDTH-1:0] reg1_out,
  output logic                  reg0_wr_pulse,
  input  logic [DATA_WIDTH-1:0] reg2_in,
  input  logic [DATA_WIDTH-1:0] reg3_in
);

  localparam int NB = DATA_WIDTH / 8;

  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [1:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
  logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
  logic                  pulse_q, pulse_d;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !w_held_q && !bvalid_q;
  assign s_axi_arready = !rvalid_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held_q && w_held_q;

  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign reg0_out      = reg0_q;
  assign reg1_out      = reg1_q;
  assign reg0_wr_pulse = pulse_q;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;
    pulse_d   = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      waddr_d   = s_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    // Commit only happens with both ready low, so it never races a handshake
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      pulse_d   = (waddr_q == 2'd0);
      unique case (waddr_q)
        2'd0:    reg0_d = merge(reg0_q, wdata_q, wstrb_q);
        2'd1:    reg1_d = merge(reg1_q, wdata_q, wstrb_q);
        default: ;
      endcase
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      unique case (s_axi_araddr[3:2])
        2'd0:    rdata_d = reg0_q;
        2'd1:    rdata_d = reg1_q;
        2'd2:    rdata_d = reg2_in;
        default: rdata_d = reg3_in;
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      reg0_q    <= '0;
      reg1_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      pulse_q   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios then random traffic
// against a register-map model.
module tb_axi_lite_reg_slave;

  logic        iclk = 1'b0;
  logic        irst;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] reg0_out;
  logic [31:0] reg1_out;
  logic        reg0_wr_pulse;
  logic [31:0] reg2_in;
  logic [31:0] reg3_in;

  always #5 iclk = ~iclk;

  axi_lite_reg_slave dut (
    .iclk(iclk), .irst(irst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg0_out(reg0_out), .reg1_out(reg1_out),
    .reg0_wr_pulse(reg0_wr_pulse),
    .reg2_in(reg2_in), .reg3_in(reg3_in)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] m0, m1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_wr(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    for (int k = 0; k < 4; k++) begin
      if (s[k] && a[3:2] == 2'd0) m0[k*8 +: 8] = d[k*8 +: 8];
      if (s[k] && a[3:2] == 2'd1) m1[k*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m0;
      2'd1:    return m1;
      2'd2:    return reg2_in;
      default: return reg3_in;
    endcase
  endfunction

  // Runs AW/W with independent start delays; returns at the negedge
  // where bvalid is first seen (lat counts negedges after the last handshake).
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input bit hold_b,
                           output int lat, output logic pb);
    bit awd = 0, wdn = 0, ahs, whs;
    s_axi_bready = !hold_b;
    for (int c = 0; c < 40 && !(awd && wdn); c++) begin
      s_axi_awaddr  = a;
      s_axi_awvalid = !awd && c >= aw_dly;
      s_axi_wdata   = d;
      s_axi_wstrb   = s;
      s_axi_wvalid  = !wdn && c >= w_dly;
      ahs = s_axi_awvalid && s_axi_awready;
      whs = s_axi_wvalid && s_axi_wready;
      @(negedge iclk);
      awd |= ahs;
      wdn |= whs;
      chk("wr_no_early_r0", reg0_out, m0);
      chk("wr_no_early_r1", reg1_out, m1);
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("wr_handshakes", {30'd0, awd, wdn}, 32'd3);
    lat = 0;
    while (!s_axi_bvalid && lat < 20) begin
      @(negedge iclk);
      lat++;
    end
    pb = reg0_wr_pulse;
    model_wr(a, d, s);
    chk("wr_bvalid", s_axi_bvalid, 1);
    chk("wr_bresp", s_axi_bresp, 0);
    chk("wr_reg0", reg0_out, m0);
    chk("wr_reg1", reg1_out, m1);
    chk("wr_pulse", pb, a[3:2] == 2'd0);
  endtask

  task automatic b_done();
    @(negedge iclk);
    chk("b_cleared", s_axi_bvalid, 0);
    chk("pulse_one_cycle", reg0_wr_pulse, 0);
    chk("awready_back", s_axi_awready, 1);
    chk("wready_back", s_axi_wready, 1);
  endtask

  task automatic axi_read(input logic [3:0] a, input int wait_c,
                          input bit scramble);
    logic [31:0] exp;
    s_axi_rready = 1'b0;
    chk("ar_ready", s_axi_arready, 1);
    exp = mdl_rd(a);
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    @(negedge iclk);
    s_axi_arvalid = 1'b0;
    chk("rd_rvalid", s_axi_rvalid, 1);
    chk("rd_rresp", s_axi_rresp, 0);
    chk("rd_data", s_axi_rdata, exp);
    for (int i = 0; i < wait_c; i++) begin
      if (scramble) begin
        reg2_in = $urandom;
        reg3_in = $urandom;
      end
      @(negedge iclk);
      chk("rd_hold_valid", s_axi_rvalid, 1);
      chk("rd_hold_data", s_axi_rdata, exp);
      chk("rd_arready_low", s_axi_arready, 0);
    end
    s_axi_rready = 1'b1;
    @(negedge iclk);
    s_axi_rready = 1'b0;
    chk("rd_rvalid_clr", s_axi_rvalid, 0);
    chk("rd_arready_back", s_axi_arready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic pb;
    logic [3:0] a;
    irst = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    reg2_in = '0; reg3_in = '0;
    m0 = '0; m1 = '0;

    // 1. reset
    repeat (5) @(negedge iclk);
    chk("rst_awready", s_axi_awready, 1);
    chk("rst_wready", s_axi_wready, 1);
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_reg0", reg0_out, 0);
    chk("rst_reg1", reg1_out, 0);
    chk("rst_pulse", reg0_wr_pulse, 0);
    irst = 1'b0;
    @(negedge iclk);

    // 2. simultaneous AW/W to 0x0
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0, lat, pb);
    chk("t2_latency", lat, 1);
    chk("t2_reg0", reg0_out, 32'd1);
    b_done();

    // 3. W ahead of AW, then a single-byte update
    axi_write(4'h4, 32'hA5A5_0000, 4'b1100, 3, 0, 0, lat, pb);
    chk("t3_reg1_a", reg1_out, 32'hA5A5_0000);
    b_done();
    axi_write(4'h4, 32'h0000_00FF, 4'b0001, 0, 2, 0, lat, pb);
    chk("t3_reg1_b", reg1_out, 32'hA5A5_00FF);
    b_done();

    // 4. B backpressure blocks further AW/W
    axi_write(4'h7, 32'h0BAD_F00D, 4'hF, 0, 0, 1, lat, pb);
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_bvalid_hold", s_axi_bvalid, 1);
      chk("t4_awready_low", s_axi_awready, 0);
      chk("t4_wready_low", s_axi_wready, 0);
      @(negedge iclk);
    end
    s_axi_bready = 1'b1;
    @(negedge iclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("t4_bvalid_clr", s_axi_bvalid, 0);
    chk("t4_aw_not_taken", s_axi_awready, 1);
    chk("t4_w_not_taken", s_axi_wready, 1);
    repeat (3) @(negedge iclk);
    chk("t4_no_commit_b", s_axi_bvalid, 0);
    chk("t4_reg0_same", reg0_out, m0);
    chk("t4_reg1", reg1_out, 32'h0BAD_F00D);

    // 5. RO registers
    reg2_in = 32'h0000_03E8;
    reg3_in = 32'h1234_5678;
    axi_read(4'h8, 4, 0);
    axi_read(4'hC, 4, 0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, lat, pb);
    b_done();
    axi_read(4'hC, 1, 0);
    chk("t5_rdata_c", s_axi_rdata, 32'h1234_5678);

    // 6. reset with only AW accepted
    s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1;
    chk("t6_awready", s_axi_awready, 1);
    @(negedge iclk);
    s_axi_awvalid = 1'b0;
    chk("t6_aw_held", s_axi_awready, 0);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    m0 = '0; m1 = '0;
    chk("t6_awready_clr", s_axi_awready, 1);
    chk("t6_reg1_zero", reg1_out, 0);
    chk("t6_reg0_zero", reg0_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      chk("t6_no_bvalid", s_axi_bvalid, 0);
    end
    axi_write(4'h4, 32'h1357_9BDF, 4'hF, 1, 0, 0, lat, pb);
    chk("t6_reg1", reg1_out, 32'h1357_9BDF);
    b_done();

    // random traffic with random low address bits
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom);
      reg2_in = $urandom;
      reg3_in = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        axi_write(a, $urandom, 4'($urandom),
                  $urandom_range(3, 0), $urandom_range(3, 0),
                  0, lat, pb);
        b_done();
      end else begin
        axi_read(a, $urandom_range(3, 0), 1);
      end
    end
    axi_read(4'h0, 0, 0);
    axi_read(4'h5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
